// File: rtl/ozdefs.sv
// ozdefs: shared LTSSM definitions.
// LTSSM_State enumerates the link training states. The ordered-set scheduler
// and its bench both take this type from here.
package ozdefs;

  typedef enum logic [3:0] {
    DETECT_QUIET,
    DETECT_ACTIVE,
    POLLING_ACTIVE,
    POLLING_ACTIVE_START_TS1,
    POLLING_COMPLIANCE,
    POLLING_CONFIG,
    CONFIG_LINKWIDTH_START,
    CONFIG_LINKWIDTH_ACCEPT,
    CONFIG_LANENUM_WAIT,
    CONFIG_COMPLETE,
    CONFIG_IDLE,
    L0,
    RECOVERY,
    DISABLED,
    LOOPBACK,
    HOT_RESET
  } LTSSM_State;

endpackage

// File: rtl/os_tx_scheduler_if.sv
// os_tx_scheduler_if: control inputs and byte-lane outputs of the ordered-set
// scheduler.
//   master: the scheduler. It takes en_n, currLtssmState and the TS1/TS2 byte
//           fields, and drives rxdata/rxdatak/rxvalid, os_type, os_start,
//           os_done and ts_sent_cnt.
//   slave:  the other end, which drives the controls and observes the lane.
interface os_tx_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic                    en_n;
  ozdefs::LTSSM_State      currLtssmState;
  logic [39:0]             ts1Bytes1Thru5;
  logic [39:0]             ts2Bytes1Thru5;
  logic [7:0]              rxdata;
  logic                    rxdatak;
  logic                    rxvalid;
  logic [1:0]              os_type;
  logic                    os_start;
  logic                    os_done;
  logic [CNT_W-1:0]        ts_sent_cnt;

  modport master (
    input  en_n, currLtssmState, ts1Bytes1Thru5, ts2Bytes1Thru5,
    output rxdata, rxdatak, rxvalid, os_type, os_start, os_done, ts_sent_cnt
  );

  modport slave (
    output en_n, currLtssmState, ts1Bytes1Thru5, ts2Bytes1Thru5,
    input  rxdata, rxdatak, rxvalid, os_type, os_start, os_done, ts_sent_cnt
  );
endinterface

// File: rtl/os_tx_scheduler.sv
// os_tx_scheduler: serialises SKP, TS1 and TS2 ordered sets onto the
// PHY-to-MAC byte lane, one byte per clock. The LTSSM state selects which set
// is sent. The stream only changes at set boundaries, so a set that has
// started is never cut short.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  os_tx_scheduler_if.master:
//          en_n, currLtssmState, ts1/ts2Bytes1Thru5  (inputs)
//          rxdata, rxdatak, rxvalid, os_type, os_start, os_done,
//          ts_sent_cnt                               (registered outputs)
// Optional: define OS_SKP_INSERT_EN to insert a SKP set into the TS1/TS2
// stream once SKP_INTERVAL TS bytes have been sent.
`ifndef COM
`define COM   8'hBC
`endif
`ifndef SKP
`define SKP   8'h1C
`endif
`ifndef TS1ID
`define TS1ID 8'h4A
`endif
`ifndef TS2ID
`define TS2ID 8'h45
`endif

module os_tx_scheduler #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  os_tx_scheduler_if.master bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND_TS  = 2'd1;
  localparam logic [1:0] SEND_SKP = 2'd2;

  localparam logic [1:0] OsNone = 2'd0;
  localparam logic [1:0] OsSkp  = 2'd1;
  localparam logic [1:0] OsTs1  = 2'd2;
  localparam logic [1:0] OsTs2  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [1:0]         type_q, type_d;     // set being sent / about to start
  logic [3:0]         ptr_q, ptr_d;       // index of next byte to emit
  logic [39:0]        bytes_q, bytes_d;   // TS bytes 1..5 latched at byte 0
  logic [7:0]         rxdata_q;
  logic               rxdatak_q, rxvalid_q, os_start_q, os_done_q;
  logic [1:0]         os_type_q;
  logic [CNT_W-1:0]   ts_cnt_q, ts_cnt_d;
  ozdefs::LTSSM_State prev_state_q;

  logic       emit, last, boundary, skp_due;
  logic [1:0] cls, nxt_type;
  logic [7:0] byte_data;
  logic       byte_k;

  // Which ordered set the current LTSSM state asks for.
  always_comb begin
    cls = OsNone;
    case (bus.currLtssmState)
      ozdefs::POLLING_ACTIVE:           cls = OsSkp;
      ozdefs::POLLING_ACTIVE_START_TS1,
      ozdefs::CONFIG_LINKWIDTH_START:   cls = OsTs1;
      ozdefs::POLLING_CONFIG:           cls = OsTs2;
      default:                          cls = OsNone;
    endcase
  end

  assign emit     = (state_q != IDLE);
  assign last     = (state_q == SEND_SKP) ? (ptr_q == 4'd3) : (ptr_q == 4'd15);
  assign boundary = !emit || last;

`ifdef OS_SKP_INSERT_EN
  localparam logic [31:0] SkpIntervalW = 32'(SKP_INTERVAL);
  logic [15:0] skp_cnt_q, skp_cnt_d;

  // Counts TS bytes. The due test uses the post-update value, so a SKP
  // becomes due on the same last byte that reaches the interval.
  always_comb begin
    skp_cnt_d = skp_cnt_q;
    if (emit && type_q == OsSkp && last) begin
      skp_cnt_d = 16'd0;
    end else if (emit && type_q[1] && skp_cnt_q != 16'hFFFF) begin
      skp_cnt_d = skp_cnt_q + 16'd1;
    end
  end

  assign skp_due = ({16'd0, skp_cnt_d} >= SkpIntervalW);

  always_ff @(posedge clk) begin
    if (rst) skp_cnt_q <= 16'd0;
    else     skp_cnt_q <= skp_cnt_d;
  end
`else
  assign skp_due = 1'b0;
`endif

  // Decide the next set. This is evaluated every cycle, but it only takes
  // effect at a boundary.
  always_comb begin
    nxt_type = OsNone;
    if (!bus.en_n && cls != OsNone) begin
      nxt_type = (skp_due && cls[1]) ? OsSkp : cls;
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    ptr_d   = emit ? ptr_q + 4'd1 : ptr_q;
    if (boundary) begin
      ptr_d  = 4'd0;
      type_d = nxt_type;
      case (nxt_type)
        OsNone:  state_d = IDLE;
        OsSkp:   state_d = SEND_SKP;
        default: state_d = SEND_TS;
      endcase
    end
  end

  // Latch the TS fields together with COM, so later input changes cannot
  // alter a set that is already on the wire.
  always_comb begin
    bytes_d = bytes_q;
    if (emit && ptr_q == 4'd0) begin
      bytes_d = (type_q == OsTs2) ? bus.ts2Bytes1Thru5 : bus.ts1Bytes1Thru5;
    end
  end

  always_comb begin
    byte_data = 8'h00;
    byte_k    = 1'b0;
    if (ptr_q == 4'd0) begin
      byte_data = `COM;
      byte_k    = 1'b1;
    end else if (state_q == SEND_SKP) begin
      byte_data = `SKP;
      byte_k    = 1'b1;
    end else begin
      case (ptr_q)
        4'd1:    byte_data = bytes_q[7:0];
        4'd2:    byte_data = bytes_q[15:8];
        4'd3:    byte_data = bytes_q[23:16];
        4'd4:    byte_data = bytes_q[31:24];
        4'd5:    byte_data = bytes_q[39:32];
        default: byte_data = (type_q == OsTs2) ? `TS2ID : `TS1ID;
      endcase
    end
  end

  // A state change clears the count. If an increment lands in the same
  // cycle, the result is 1.
  always_comb begin
    logic inc;
    inc      = emit && last && type_q[1];
    ts_cnt_d = ts_cnt_q;
    if (bus.currLtssmState != prev_state_q) begin
      ts_cnt_d = inc ? CNT_W'(1) : '0;
    end else if (inc && ts_cnt_q != {CNT_W{1'b1}}) begin
      ts_cnt_d = ts_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      type_q       <= OsNone;
      ptr_q        <= 4'd0;
      bytes_q      <= 40'd0;
      rxdata_q     <= 8'd0;
      rxdatak_q    <= 1'b0;
      rxvalid_q    <= 1'b0;
      os_type_q    <= OsNone;
      os_start_q   <= 1'b0;
      os_done_q    <= 1'b0;
      ts_cnt_q     <= '0;
      prev_state_q <= ozdefs::DETECT_QUIET;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      ptr_q        <= ptr_d;
      bytes_q      <= bytes_d;
      rxdata_q     <= emit ? byte_data : 8'd0;
      rxdatak_q    <= emit && byte_k;
      rxvalid_q    <= emit;
      os_type_q    <= emit ? type_q : OsNone;
      os_start_q   <= emit && (ptr_q == 4'd0);
      os_done_q    <= emit && last;
      ts_cnt_q     <= ts_cnt_d;
      prev_state_q <= bus.currLtssmState;
    end
  end

  assign bus.rxdata      = rxdata_q;
  assign bus.rxdatak     = rxdatak_q;
  assign bus.rxvalid     = rxvalid_q;
  assign bus.os_type     = os_type_q;
  assign bus.os_start    = os_start_q;
  assign bus.os_done     = os_done_q;
  assign bus.ts_sent_cnt = ts_cnt_q;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Bench for os_tx_scheduler. It drives two instances, one with CNT_W=16 and
// one with CNT_W=2, from the same inputs. Both are checked each cycle against
// a model that holds the expected lane beats in a queue.
module tb_os_tx_scheduler;
  import ozdefs::*;

  localparam int SkpInterval = 32;

  typedef struct packed {
    logic       v;
    logic       k;
    logic [1:0] t;
    logic       s;
    logic       e;
    logic [7:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_n;
  LTSSM_State  ltssm;
  logic [39:0] ts1, ts2;

  int n_cmp = 0;
  int n_err = 0;

  os_tx_scheduler_if #(.CNT_W(16)) bus_a ();
  os_tx_scheduler_if #(.CNT_W(2))  bus_b ();

  assign bus_a.en_n = en_n;
  assign bus_a.currLtssmState = ltssm;
  assign bus_a.ts1Bytes1Thru5 = ts1;
  assign bus_a.ts2Bytes1Thru5 = ts2;
  assign bus_b.en_n = en_n;
  assign bus_b.currLtssmState = ltssm;
  assign bus_b.ts1Bytes1Thru5 = ts1;
  assign bus_b.ts2Bytes1Thru5 = ts2;

  os_tx_scheduler #(.SKP_INTERVAL(SkpInterval), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  os_tx_scheduler #(.SKP_INTERVAL(SkpInterval), .CNT_W(2)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Model state.
  beat_t      m_q[$];
  beat_t      cur;
  logic [1:0] m_pend;
  int         m_cnt, m_skp;
  LTSSM_State m_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] class_of(input LTSSM_State s);
    case (s)
      POLLING_ACTIVE:                                   return 2'd1;
      POLLING_ACTIVE_START_TS1, CONFIG_LINKWIDTH_START: return 2'd2;
      POLLING_CONFIG:                                   return 2'd3;
      default:                                          return 2'd0;
    endcase
  endfunction

  task automatic push_set(input logic [1:0] t, input logic [39:0] b);
    int    n;
    beat_t bt;
    n = (t == 2'd1) ? 4 : 16;
    for (int i = 0; i < n; i++) begin
      bt   = '0;
      bt.v = 1'b1;
      bt.t = t;
      bt.s = (i == 0);
      bt.e = (i == n - 1);
      if (i == 0) begin
        bt.k = 1'b1; bt.d = 8'hBC;
      end else if (t == 2'd1) begin
        bt.k = 1'b1; bt.d = 8'h1C;
      end else if (i <= 5) begin
        bt.d = b[8*(i-1) +: 8];
      end else begin
        bt.d = (t == 2'd3) ? 8'h45 : 8'h4A;
      end
      m_q.push_back(bt);
    end
  endtask

  // Advance the model by one clock edge, using the inputs sampled at that edge.
  task automatic step_model();
    logic       bnd, due;
    logic [1:0] c;
    if (rst) begin
      m_q.delete();
      m_pend = 2'd0;
      cur    = '0;
      m_cnt  = 0;
      m_skp  = 0;
      m_prev = DETECT_QUIET;
      return;
    end
    if (m_pend != 2'd0) begin
      push_set(m_pend, (m_pend == 2'd3) ? ts2 : ts1);
      m_pend = 2'd0;
    end
    if (m_q.size() > 0) begin
      cur = m_q.pop_front();
      bnd = (m_q.size() == 0);
    end else begin
      cur = '0;
      bnd = 1'b1;
    end
    if (ltssm != m_prev) m_cnt = 0;
    if (cur.e && cur.t[1]) m_cnt++;
    m_prev = ltssm;
    if (cur.t == 2'd1 && cur.e) m_skp = 0;
    else if (cur.t[1] && m_skp < 65535) m_skp++;
`ifdef OS_SKP_INSERT_EN
    due = (m_skp >= SkpInterval);
`else
    due = 1'b0;
`endif
    if (bnd) begin
      c = class_of(ltssm);
      if (en_n || c == 2'd0) m_pend = 2'd0;
      else if (c[1] && due)  m_pend = 2'd1;
      else                   m_pend = c;
    end
  endtask

  task automatic compare();
    int cap_a, cap_b;
    cap_a = (m_cnt > 65535) ? 65535 : m_cnt;
    cap_b = (m_cnt > 3) ? 3 : m_cnt;
    check("lane16", 32'({bus_a.rxvalid, bus_a.rxdatak, bus_a.os_type, bus_a.os_start,
                         bus_a.os_done, bus_a.rxdata}), 32'(cur));
    check("lane2", 32'({bus_b.rxvalid, bus_b.rxdatak, bus_b.os_type, bus_b.os_start,
                        bus_b.os_done, bus_b.rxdata}), 32'(cur));
    check("cnt16", 32'(bus_a.ts_sent_cnt), 32'(cap_a));
    check("cnt2", 32'(bus_b.ts_sent_cnt), 32'(cap_b));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      step_model();
      #1;
      compare();
    end
  endtask

  initial begin
    logic [63:0] r;
    LTSSM_State  hot[4];
    hot[0] = POLLING_ACTIVE;
    hot[1] = POLLING_ACTIVE_START_TS1;
    hot[2] = POLLING_CONFIG;
    hot[3] = CONFIG_LINKWIDTH_START;

    rst = 1'b1; en_n = 1'b1; ltssm = DETECT_QUIET; ts1 = '0; ts2 = '0;
    run(3);
    // SKP stream.
    rst = 1'b0; en_n = 1'b0; ltssm = POLLING_ACTIVE;
    run(20);
    // TS1 with known fields, then a state change in the middle of a set.
    ltssm = POLLING_ACTIVE_START_TS1; ts1 = 40'h0504030201; ts2 = 40'h0A09080706;
    run(37);
    ltssm = POLLING_CONFIG;
    run(40);
    // Disable in the middle of a set.
    en_n = 1'b1;
    run(30);
    // Long TS1 run: reaches counter saturation and SKP insertion.
    en_n = 1'b0; ltssm = POLLING_ACTIVE_START_TS1;
    run(120);
    // Reset in the middle of a set.
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(40);
    // Randomised phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        if ($urandom_range(0, 1) == 1) ltssm = hot[$urandom_range(0, 3)];
        else ltssm = LTSSM_State'(4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 24) == 0) en_n = ~en_n;
      if ($urandom_range(0, 7) == 0) begin
        r = {$urandom(), $urandom()};
        ts1 = r[39:0];
      end
      if ($urandom_range(0, 7) == 0) begin
        r = {$urandom(), $urandom()};
        ts2 = r[39:0];
      end
      rst = ($urandom_range(0, 299) == 0);
      run(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
